pir_stimulus_gen: RTL and testbench



---
 rtl/pir_stimulus_gen.sv | 188 ++++++++++++++++++
 tb/tb_pir_stimulus_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pir_stimulus_gen.sv
// Mode-driven PIR stimulus sequencer: arm, active pattern, release, stop.
// Drives turn, stop_alarm and NUM_CH sensor words for the detection core.
module pir_stimulus_gen #(
    parameter int NUM_CH    = 3,
    parameter int SENS_W    = 7,
    parameter int ARM_CYC   = 2,
    parameter int STEP_CYC  = 5,
    parameter int RUN_STEPS = 4,
    parameter int HOLD_CYC  = 5,
    parameter int RAMP_INC  = 40,
    parameter int LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [1:0]                    mode,
    output logic                          turn,
    output logic                          stop_alarm,
    output logic [NUM_CH*SENS_W-1:0]      pir_sensor,
    output logic [$clog2(RUN_STEPS):0]    step_idx,
    output logic                          busy,
    output logic                          done
);

    localparam int STEP_W = $clog2(RUN_STEPS) + 1;
    localparam int CNT_W  = 16;
    localparam int PIR_W  = NUM_CH * SENS_W;

    localparam logic [CNT_W-1:0]  ARM_LAST  = CNT_W'(ARM_CYC - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(RUN_STEPS - 1);
    localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
    localparam logic [LFSR_W-1:0] SEED_EFF  =
        (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RUN, S_REL, S_STOP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [1:0]          mode_q, mode_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [PIR_W-1:0]    pir_q, pir_d;
    logic                turn_q, turn_d;
    logic                stop_q, stop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] x
    );
        return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
    endfunction

    function automatic logic [PIR_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [STEP_W-1:0] s,
        input logic [LFSR_W-1:0] l
    );
        logic [PIR_W-1:0]  v;
        logic [SENS_W-1:0] w;
        logic [LFSR_W-1:0] rot;
        int                r;
        v = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            r   = (3 * k) % LFSR_W;
            rot = (l >> r) | (l << (LFSR_W - r));
            unique case (m)
                2'd0: w = SENS_W'(29 + 27 * k);
                2'd1: w = rot[SENS_W-1:0];
                2'd2: w = SENS_W'(int'(s) * RAMP_INC + 16 * k);
                default: w = ((int'(s) % NUM_CH) == k) ? '1 : '0;
            endcase
            v[k*SENS_W +: SENS_W] = w;
        end
        return v;
    endfunction

    // State, counters, pattern source and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
            mode_q  <= '0;
            lfsr_q  <= SEED_EFF;
            pir_q   <= '0;
            turn_q  <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            lfsr_q  <= lfsr_d;
            pir_q   <= pir_d;
            turn_q  <= turn_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Sequencing; outputs follow the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        step_d  = step_q;
        mode_d  = mode_q;
        lfsr_d  = lfsr_q;
        pir_d   = pir_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_ARM;
                    mode_d  = mode;
                    lfsr_d  = SEED_EFF;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end else if (cnt_q == ARM_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    step_d  = '0;
                    pir_d   = pattern(mode_q, '0, lfsr_q);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                    step_d  = '0;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (step_q == LAST_STEP) begin
                        state_d = S_REL;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                        lfsr_d = lfsr_next(lfsr_q);
                        pir_d  = pattern(mode_q, step_d, lfsr_d);
                    end
                end
            end
            S_REL: begin
                if (abort || cnt_q == HOLD_LAST) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                state_d = S_DONE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_d != S_RUN) begin
            pir_d = '0;
        end
        turn_d = (state_d == S_ARM) || (state_d == S_RUN)
              || (state_d == S_REL);
        busy_d = turn_d || (state_d == S_STOP);
        stop_d = (state_d == S_STOP);
        done_d = (state_d == S_DONE);
    end

    assign turn       = turn_q;
    assign stop_alarm = stop_q;
    assign pir_sensor = pir_q;
    assign step_idx   = step_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pir_stimulus_gen.sv
// Scoreboard bench for pir_stimulus_gen with default parameters.
// Expected per-cycle outputs are queued at launch; a monitor compares.
module tb_pir_stimulus_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic        turn;
    logic        stop_alarm;
    logic [20:0] pir_sensor;
    logic [2:0]  step_idx;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;
    int sc     = 0;

    typedef struct {
        logic        turn;
        logic        stop;
        logic        busy;
        logic        done;
        logic [20:0] pir;
        logic [2:0]  step;
        int          cyc;
        int          sc;
    } exp_t;

    exp_t        exp_q[$];
    logic [20:0] tbl[4][4];

    pir_stimulus_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .turn       (turn),
        .stop_alarm (stop_alarm),
        .pir_sensor (pir_sensor),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Expected outputs for cycle c of a run (start sampled at edge 0).
    function automatic exp_t exp_at(input int m, input int c,
                                    input int ab, input int rs);
        exp_t e;
        e.turn = 0; e.stop = 0; e.busy = 0; e.done = 0;
        e.pir = '0; e.step = '0; e.cyc = c; e.sc = sc;
        if (rs != 0 && c > rs) return e;
        if (ab != 0 && c > ab) begin
            if (c == ab + 1) begin e.stop = 1; e.busy = 1; end
            if (c == ab + 2) e.done = 1;
            return e;
        end
        if (c <= 2) begin
            e.turn = 1; e.busy = 1;
        end else if (c <= 22) begin
            e.turn = 1; e.busy = 1;
            e.step = 3'((c - 3) / 5);
            e.pir  = tbl[m][(c - 3) / 5];
        end else if (c <= 27) begin
            e.turn = 1; e.busy = 1;
        end else if (c == 28) begin
            e.stop = 1; e.busy = 1;
        end else if (c == 29) begin
            e.done = 1;
        end
        return e;
    endfunction

    // Monitor: one comparison per queued cycle, sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if (turn !== e.turn || stop_alarm !== e.stop ||
                    busy !== e.busy || done !== e.done ||
                    pir_sensor !== e.pir || step_idx !== e.step) begin
                    n_fail++;
                    $display("FAIL sc%0d cyc%0d: got t%b s%b b%b d%b pir=%h st=%0d, want t%b s%b b%b d%b pir=%h st=%0d",
                             e.sc, e.cyc, turn, stop_alarm, busy, done,
                             pir_sensor, step_idx, e.turn, e.stop,
                             e.busy, e.done, e.pir, e.step);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        n_chk++;
        if ({turn, stop_alarm, busy, done} !== 4'b0 ||
            pir_sensor !== '0 || step_idx !== '0) begin
            n_fail++;
            $display("FAIL %s: got t%b s%b b%b d%b pir=%h st=%0d, want all 0",
                     name, turn, stop_alarm, busy, done,
                     pir_sensor, step_idx);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain sc%0d: %0d entries left, want 0",
                     sc, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // One run: ab = abort cycle, rs = reset cycle, ex = misuse inputs.
    task automatic drive_run(input int m, input int ab,
                             input int rs, input bit ex);
        int n;
        sc++;
        n = (ab != 0) ? ab + 3 : (rs != 0) ? rs + 3 : 31;
        @(negedge clk);
        mode  = 2'(m);
        start = 1'b1;
        abort = ex;
        for (int c = 1; c <= n; c++) exp_q.push_back(exp_at(m, c, ab, rs));
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (ex) begin
                if (c >= 5) mode = 2'(3 - m);
                start = (c == 25) || (c == 29);
                abort = (c == 28);
            end
            if (ab != 0) begin
                start = (c == 8);
                abort = (c == ab);
            end
            if (rs != 0 && c == rs) begin
                rst = 1'b1;
                #1 check_zero("async_rst");
            end
            if (rs != 0 && c == rs + 3) rst = 1'b0;
        end
        start = 1'b0;
        abort = 1'b0;
        drain();
    endtask

    initial begin
        for (int s = 0; s < 4; s++) tbl[0][s] = {7'd83, 7'd56, 7'd29};
        tbl[1][0] = {7'd51, 7'd28, 7'd97};
        tbl[1][1] = {7'd9, 7'd78, 7'd112};
        tbl[1][2] = {7'd68, 7'd39, 7'd56};
        tbl[1][3] = {7'd98, 7'd19, 7'd28};
        tbl[2][0] = {7'd32, 7'd16, 7'd0};
        tbl[2][1] = {7'd72, 7'd56, 7'd40};
        tbl[2][2] = {7'd112, 7'd96, 7'd80};
        tbl[2][3] = {7'd24, 7'd8, 7'd120};
        tbl[3][0] = {7'd0, 7'd0, 7'd127};
        tbl[3][1] = {7'd0, 7'd127, 7'd0};
        tbl[3][2] = {7'd127, 7'd0, 7'd0};
        tbl[3][3] = {7'd0, 7'd0, 7'd127};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("idle");

        drive_run(0, 0, 0, 1'b1);
        drive_run(1, 0, 0, 1'b0);
        drive_run(1, 0, 0, 1'b0);
        drive_run(2, 0, 0, 1'b0);
        drive_run(3, 0, 0, 1'b0);
        drive_run(0, 10, 0, 1'b0);
        drive_run(2, 0, 15, 1'b0);
        drive_run(0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
